// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
// Package     : connect4_pkg
// Description : Shared command/issuer types and UART command byte encodings
//               for the Connect-4 move-command path.
// Revision    : 1.0 - initial release
// ============================================================================
package connect4_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LEFT  = 2'd1,
        CMD_RIGHT = 2'd2,
        CMD_DROP  = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } issuer_state_t;

    localparam logic [7:0] UART_CMD_RIGHT = 8'h01;
    localparam logic [7:0] UART_CMD_LEFT  = 8'h02;
    localparam logic [7:0] UART_CMD_DROP  = 8'h03;

    // Any byte outside the three command codes maps to CMD_NONE.
    function automatic cmd_t uart_decode(input logic [7:0] b);
        case (b)
            UART_CMD_RIGHT: return CMD_RIGHT;
            UART_CMD_LEFT:  return CMD_LEFT;
            UART_CMD_DROP:  return CMD_DROP;
            default:        return CMD_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : move_cmd_arbiter_if
// Description : Front-end request inputs and FSM-facing move outputs of the
//               move-command arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface move_cmd_arbiter_if;

    logic       btn_left;
    logic       btn_right;
    logic       btn_drop;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       game_ready;
    logic       player_turn;
    logic       move_left;
    logic       move_right;
    logic       move_made;
    logic       times_up;
    logic [3:0] seconds;
    logic       overflow;
    logic       bad_cmd;

    modport master (
        output btn_left, btn_right, btn_drop, rx_valid, rx_data,
               game_ready, player_turn,
        input  move_left, move_right, move_made, times_up,
               seconds, overflow, bad_cmd
    );

    modport slave (
        input  btn_left, btn_right, btn_drop, rx_valid, rx_data,
               game_ready, player_turn,
        output move_left, move_right, move_made, times_up,
               seconds, overflow, bad_cmd
    );

endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous command FIFO with flush; push and pop in the same
//               cycle are accepted even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo
    import connect4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_push,
    input  cmd_t      i_push_cmd,
    input  wire logic i_pop,
    input  wire logic i_flush,
    output logic      o_full,
    output logic      o_empty,
    output cmd_t      o_head
);

    localparam int ADDR_W = $clog2(DEPTH);

    cmd_t              r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign o_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

    // Flush dominates; a full FIFO still takes a push when it pops.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_push_cmd;
    end

endmodule
`default_nettype wire

// File: rtl/move_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : move_cmd_arbiter
// Description : Merges button and UART move requests into one paced command
//               stream for connect4_fsm and owns the per-turn timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module move_cmd_arbiter
    import connect4_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int GAP_CYCLES    = 4,
    parameter int TICKS_PER_SEC = 25_000_000,
    parameter int TIMEOUT_SECS  = 10
) (
    input  wire logic          clk,
    input  wire logic          reset,
    move_cmd_arbiter_if.slave  bus
);

    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [GAP_W-1:0]  c_GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]        c_TIMEOUT   = 4'(TIMEOUT_SECS);

    cmd_t              w_btn_cmd;
    cmd_t              w_rx_cmd;
    logic              w_rx_bad;
    cmd_t              w_push_cmd;
    logic              w_push;
    logic              w_skid_load;
    logic              w_skid_take;
    logic              w_rx_lost;
    logic              r_skid_valid;
    cmd_t              r_skid_cmd;

    logic              w_full;
    logic              w_empty;
    cmd_t              w_head;
    logic              w_pop;
    logic              w_flush;
    logic              w_gap_last;
    logic              w_can_issue;
    logic              w_timeout;
    logic              w_fire;
    logic              w_timer_clr;
    logic              w_turn_change;

    issuer_state_t     r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [TICK_W-1:0] r_tick;
    logic [3:0]        r_seconds;
    logic              r_fired;
    logic              r_turn_q;
    logic              r_move_left;
    logic              r_move_right;
    logic              r_move_made;
    logic              r_times_up;
    logic              r_overflow;
    logic              r_bad_cmd;

    always_comb begin
        w_btn_cmd = CMD_NONE;
        if (bus.btn_drop)       w_btn_cmd = CMD_DROP;
        else if (bus.btn_left)  w_btn_cmd = CMD_LEFT;
        else if (bus.btn_right) w_btn_cmd = CMD_RIGHT;
    end

    assign w_rx_cmd = bus.rx_valid ? uart_decode(bus.rx_data) : CMD_NONE;
    assign w_rx_bad = bus.rx_valid && (uart_decode(bus.rx_data) == CMD_NONE);

    // One FIFO push per cycle: button, then skid, then UART.
    always_comb begin
        w_push      = 1'b0;
        w_push_cmd  = CMD_NONE;
        w_skid_load = 1'b0;
        w_skid_take = 1'b0;
        w_rx_lost   = 1'b0;
        if (w_btn_cmd != CMD_NONE) begin
            w_push     = 1'b1;
            w_push_cmd = w_btn_cmd;
            if (w_rx_cmd != CMD_NONE) begin
                if (r_skid_valid) w_rx_lost   = 1'b1;
                else              w_skid_load = 1'b1;
            end
        end else if (r_skid_valid) begin
            w_push      = 1'b1;
            w_push_cmd  = r_skid_cmd;
            w_skid_take = 1'b1;
            w_skid_load = (w_rx_cmd != CMD_NONE);
        end else if (w_rx_cmd != CMD_NONE) begin
            w_push     = 1'b1;
            w_push_cmd = w_rx_cmd;
        end
    end

    // The final GAP cycle also acts as IDLE so back-to-back pulses are
    // separated by exactly GAP_CYCLES quiet cycles.
    assign w_gap_last    = (r_state == GAP) && (r_gap_cnt == c_GAP_LAST);
    assign w_can_issue   = bus.game_ready && !w_empty &&
                           ((r_state == IDLE) || w_gap_last);
    assign w_timeout     = bus.game_ready && (r_seconds == c_TIMEOUT) && !r_fired &&
                           ((r_state == IDLE) || (r_state == GAP));
    assign w_fire        = w_timeout && !(w_can_issue && (w_head == CMD_DROP));
    assign w_pop         = w_can_issue && !w_fire;
    assign w_flush       = !bus.game_ready || w_fire;
    assign w_turn_change = (bus.player_turn != r_turn_q);
    assign w_timer_clr   = !bus.game_ready || w_fire || w_turn_change ||
                           (w_pop && (w_head == CMD_DROP));

    cmd_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_push     (w_push && bus.game_ready),
        .i_push_cmd (w_push_cmd),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset || !bus.game_ready) begin
            r_skid_valid <= 1'b0;
            r_skid_cmd   <= CMD_NONE;
        end else if (w_skid_load) begin
            r_skid_valid <= 1'b1;
            r_skid_cmd   <= w_rx_cmd;
        end else if (w_skid_take) begin
            r_skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_bad_cmd  <= 1'b0;
        end else begin
            r_bad_cmd <= w_rx_bad;
            if (bus.game_ready && !w_fire &&
                (w_rx_lost || (w_push && w_full && !w_pop)))
                r_overflow <= 1'b1;
        end
    end

    // A timeout pulse occupies the ISSUE slot so GAP always follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_gap_cnt    <= '0;
            r_fired      <= 1'b0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_move_made  <= 1'b0;
            r_times_up   <= 1'b0;
        end else begin
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_move_made  <= 1'b0;
            r_times_up   <= 1'b0;
            if (w_turn_change) r_fired <= 1'b0;
            if (!bus.game_ready) begin
                r_state   <= IDLE;
                r_gap_cnt <= '0;
            end else if (w_fire) begin
                r_move_made <= 1'b1;
                r_times_up  <= 1'b1;
                r_fired     <= 1'b1;
                r_state     <= ISSUE;
            end else if (w_pop) begin
                r_move_left  <= (w_head == CMD_LEFT);
                r_move_right <= (w_head == CMD_RIGHT);
                r_move_made  <= (w_head == CMD_DROP);
                r_state      <= ISSUE;
            end else begin
                case (r_state)
                    ISSUE: begin
                        r_state   <= GAP;
                        r_gap_cnt <= '0;
                    end
                    GAP: begin
                        if (w_gap_last) r_state   <= IDLE;
                        else            r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_turn_q  <= 1'b0;
            r_tick    <= '0;
            r_seconds <= '0;
        end else begin
            r_turn_q <= bus.player_turn;
            if (w_timer_clr) begin
                r_tick    <= '0;
                r_seconds <= '0;
            end else if (r_tick == c_TICK_LAST) begin
                r_tick <= '0;
                if (r_seconds != c_TIMEOUT) r_seconds <= r_seconds + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    assign bus.move_left  = r_move_left;
    assign bus.move_right = r_move_right;
    assign bus.move_made  = r_move_made;
    assign bus.times_up   = r_times_up;
    assign bus.seconds    = r_seconds;
    assign bus.overflow   = r_overflow;
    assign bus.bad_cmd    = r_bad_cmd;

endmodule
`default_nettype wire

// File: tb/tb_move_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_cmd_arbiter
// Description : Directed self-checking bench for move_cmd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_cmd_arbiter;

    localparam logic [7:0] c_P_NONE = 8'h00;
    localparam logic [7:0] c_P_L    = 8'h08;
    localparam logic [7:0] c_P_R    = 8'h04;
    localparam logic [7:0] c_P_M    = 8'h02;
    localparam logic [7:0] c_P_MT   = 8'h03;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    move_cmd_arbiter_if bus ();

    move_cmd_arbiter #(
        .FIFO_DEPTH    (4),
        .GAP_CYCLES    (4),
        .TICKS_PER_SEC (10),
        .TIMEOUT_SECS  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_drop  = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
    endtask

    function automatic logic [7:0] pulses();
        return {4'b0000, bus.move_left, bus.move_right, bus.move_made, bus.times_up};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Number of cycles with any output pulse over n ticks.
    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            cnt += int'(pulses() != c_P_NONE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        int made;
        clear_in();
        bus.game_ready  = 1'b0;
        bus.player_turn = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_pulses",   pulses(),               c_P_NONE);
        chk("rst_seconds",  {4'b0, bus.seconds},    8'd0);
        chk("rst_overflow", {7'b0, bus.overflow},   8'd0);
        chk("rst_bad_cmd",  {7'b0, bus.bad_cmd},    8'd0);
        reset = 1'b0;
        bus.game_ready = 1'b1;
        tick();

        // Single right request: one pulse, one cycle after it reaches the head.
        bus.btn_right = 1'b1;
        tick();
        clear_in();
        chk("t1_latency", pulses(), c_P_NONE);
        tick();
        chk("t1_right", pulses(), c_P_R);
        count_pulses(6, cnt);
        chk("t1_no_extra", 8'(cnt), 8'd0);

        // Button plus UART drop in the same cycle: left first, drop via skid.
        bus.game_ready = 1'b0;
        tick();
        bus.game_ready = 1'b1;
        tick();
        bus.btn_left = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h03;
        tick();
        clear_in();
        chk("t2_wait", pulses(), c_P_NONE);
        tick();
        chk("t2_left", pulses(), c_P_L);
        count_pulses(4, cnt);
        chk("t2_gap_quiet", 8'(cnt), 8'd0);
        tick();
        chk("t2_drop", pulses(), c_P_M);
        chk("t2_overflow", {7'b0, bus.overflow}, 8'd0);
        chk("t2_bad_cmd",  {7'b0, bus.bad_cmd},  8'd0);

        // Six UART drops starting in the ISSUE cycle: fifth rides a pop, sixth overflows.
        for (int i = 0; i < 4; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h03;
            tick();
        end
        bus.rx_valid = 1'b1;
        tick();
        chk("t3_pop_drop", pulses(), c_P_M);
        chk("t3_full_pop_no_ovf", {7'b0, bus.overflow}, 8'd0);
        tick();
        clear_in();
        chk("t3_full_ovf", {7'b0, bus.overflow}, 8'd1);
        made = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            made += int'(bus.move_made);
        end
        chk("t3_drain_count", 8'(made), 8'd4);

        // Pushes while game_ready is low are flushed without overflow.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.game_ready = 1'b0;
        chk("t3b_rst_ovf", {7'b0, bus.overflow}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h03;
            tick();
        end
        clear_in();
        chk("t3b_no_ovf", {7'b0, bus.overflow}, 8'd0);

        // Idle turn: seconds 1..10 at 10 cycles/second, then automatic drop.
        bus.game_ready = 1'b1;
        cnt = 0;
        for (int j = 1; j <= 100; j++) begin
            tick();
            cnt += int'(pulses() != c_P_NONE);
            if (j % 20 == 0) chk("t4_seconds", {4'b0, bus.seconds}, 8'(j / 10));
        end
        chk("t4_quiet", 8'(cnt), 8'd0);
        chk("t4_at_limit", {4'b0, bus.seconds}, 8'd10);
        tick();
        chk("t4_timeout_pulse", pulses(), c_P_MT);
        chk("t4_seconds_clr", {4'b0, bus.seconds}, 8'd0);
        tick();
        chk("t4_single_pulse", pulses(), c_P_NONE);

        // New turn; a drop reaching the head as the limit hits wins over timeout.
        bus.player_turn = 1'b1;
        tick();
        count_pulses(99, cnt);
        chk("t4b_quiet", 8'(cnt), 8'd0);
        bus.btn_drop = 1'b1;
        tick();
        clear_in();
        chk("t4b_limit", {4'b0, bus.seconds}, 8'd10);
        chk("t4b_wait", pulses(), c_P_NONE);
        tick();
        chk("t4b_drop_wins", pulses(), c_P_M);
        chk("t4b_timer_clr", {4'b0, bus.seconds}, 8'd0);

        // Button collision: drop beats left and right, losers vanish.
        count_pulses(6, cnt);
        bus.btn_drop  = 1'b1;
        bus.btn_left  = 1'b1;
        bus.btn_right = 1'b1;
        tick();
        clear_in();
        tick();
        chk("t5_collision", pulses(), c_P_M);
        count_pulses(8, cnt);
        chk("t5_losers_gone", 8'(cnt), 8'd0);
        chk("t5_no_ovf", {7'b0, bus.overflow}, 8'd0);

        // Illegal UART byte.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h7F;
        tick();
        clear_in();
        chk("t6_bad_cmd", {7'b0, bus.bad_cmd}, 8'd1);
        chk("t6_no_pulse", pulses(), c_P_NONE);
        tick();
        chk("t6_bad_cmd_1cyc", {7'b0, bus.bad_cmd}, 8'd0);
        count_pulses(6, cnt);
        chk("t6_fifo_empty", 8'(cnt), 8'd0);

        // Reset one cycle into GAP with two commands queued.
        bus.btn_right = 1'b1;
        tick();
        bus.btn_right = 1'b0;
        bus.btn_left  = 1'b1;
        tick();
        chk("t7_right", pulses(), c_P_R);
        bus.btn_left = 1'b0;
        bus.btn_drop = 1'b1;
        tick();
        clear_in();
        reset = 1'b1;
        tick();
        chk("t7_rst_pulses",  pulses(),             c_P_NONE);
        chk("t7_rst_seconds", {4'b0, bus.seconds},  8'd0);
        chk("t7_rst_ovf",     {7'b0, bus.overflow}, 8'd0);
        reset = 1'b0;
        count_pulses(15, cnt);
        chk("t7_queue_cleared", 8'(cnt), 8'd0);
        bus.btn_left = 1'b1;
        tick();
        clear_in();
        tick();
        chk("t7_alive", pulses(), c_P_L);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
